// File: rtl/cache_pkg.sv
// Shared encodings for the MSI snooping cache node: line states, FSM states,
// and the flag field that heads every bus word.
package cache_pkg;

    localparam logic [1:0] LS_I = 2'b00;
    localparam logic [1:0] LS_S = 2'b01;
    localparam logic [1:0] LS_M = 2'b10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_INV       = 3'd2;
    localparam logic [2:0] ST_WB        = 3'd3;
    localparam logic [2:0] ST_MISS_REQ  = 3'd4;
    localparam logic [2:0] ST_FILL_WAIT = 3'd5;

    localparam int FLAG_W = 4;

    // Flag field order matches the bus word, MSB first.
    typedef struct packed {
        logic rd_miss;
        logic wr_miss;
        logic inval;
        logic wb;
    } bus_flags_t;

    function automatic bus_flags_t pack_flags(input logic rd, input logic wr,
                                              input logic inv, input logic wb);
        bus_flags_t f;
        f.rd_miss = rd;
        f.wr_miss = wr;
        f.inval   = inv;
        f.wb      = wb;
        return f;
    endfunction

    function automatic bus_flags_t unpack_flags(input logic [FLAG_W-1:0] w);
        return bus_flags_t'(w);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage {state, tag, data}: one full-entry CPU write port,
// one state-only snoop port that wins on the same index, two combinational reads.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int NUM_LINES = 2,
    parameter int IDX_W     = 1,
    parameter int TAG_W     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [IDX_W-1:0]  cpu_idx,
    input  logic [1:0]        cpu_state,
    input  logic [TAG_W-1:0]  cpu_tag,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              snp_we,
    input  logic [IDX_W-1:0]  snp_idx,
    input  logic [1:0]        snp_state,
    input  logic [IDX_W-1:0]  rd_a_idx,
    output logic [1:0]        rd_a_state,
    output logic [TAG_W-1:0]  rd_a_tag,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [IDX_W-1:0]  rd_b_idx,
    output logic [1:0]        rd_b_state,
    output logic [TAG_W-1:0]  rd_b_tag,
    output logic [DATA_W-1:0] rd_b_data
);

    logic [1:0]        state_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [DATA_W-1:0] data_q  [NUM_LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= LS_I;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (cpu_we) begin
                state_q[cpu_idx] <= cpu_state;
                tag_q[cpu_idx]   <= cpu_tag;
                data_q[cpu_idx]  <= cpu_data;
            end
            // Later assignment gives the snoop port priority on a shared index.
            if (snp_we) begin
                state_q[snp_idx] <= snp_state;
            end
        end
    end

    assign rd_a_state = state_q[rd_a_idx];
    assign rd_a_tag   = tag_q[rd_a_idx];
    assign rd_a_data  = data_q[rd_a_idx];
    assign rd_b_state = state_q[rd_b_idx];
    assign rd_b_tag   = tag_q[rd_b_idx];
    assign rd_b_data  = data_q[rd_b_idx];

endmodule

// File: rtl/cache_node_msi.sv
// Per-CPU MSI snooping cache node: one CPU request at a time, snoops every cycle.
// Optional CACHE_NODE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_node_msi
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 4,
    parameter int NUM_LINES = 2,
    parameter int BUS_W     = 4 + ADDR_W + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              execute_instruction,
    input  logic              instruction,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [BUS_W-1:0]  bus_out,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data
`ifdef CACHE_NODE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [2:0]        state_q, state_d;
    logic              req_wr_q, req_wr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              snp_wb_vld_q, snp_wb_vld_d;
    logic [ADDR_W-1:0] snp_wb_addr_q;
    logic [DATA_W-1:0] snp_wb_data_q;

    logic              cpu_we;
    logic [1:0]        cpu_state;
    logic [TAG_W-1:0]  cpu_tag;
    logic [DATA_W-1:0] cpu_data;
    logic              snp_we, snp_upd, snp_wb, snp_hit, snp_on_req, fill_install;
    logic [1:0]        snp_new;
    logic              cnt_hit, cnt_miss, hit;

    logic [1:0]        a_state, b_state;
    logic [TAG_W-1:0]  a_tag, b_tag;
    logic [DATA_W-1:0] a_data, b_data;

    logic [IDX_W-1:0]  req_idx, snp_idx;
    logic [TAG_W-1:0]  req_tag, snp_tag;
    bus_flags_t        bin_fl;
    logic [ADDR_W-1:0] bin_addr;
    logic              unused_bus_data;

    assign req_idx  = req_addr_q[IDX_W-1:0];
    assign req_tag  = req_addr_q[ADDR_W-1:IDX_W];
    assign bin_fl   = unpack_flags(bus_in[BUS_W-1 -: FLAG_W]);
    assign bin_addr = bus_in[DATA_W +: ADDR_W];
    assign snp_idx  = bin_addr[IDX_W-1:0];
    assign snp_tag  = bin_addr[ADDR_W-1:IDX_W];
    assign unused_bus_data = ^bus_in[DATA_W-1:0];

    cache_line_array #(
        .DATA_W   (DATA_W),
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_idx   (req_idx),
        .cpu_state (cpu_state),
        .cpu_tag   (cpu_tag),
        .cpu_data  (cpu_data),
        .snp_we    (snp_we),
        .snp_idx   (snp_idx),
        .snp_state (snp_new),
        .rd_a_idx  (req_idx),
        .rd_a_state(a_state),
        .rd_a_tag  (a_tag),
        .rd_a_data (a_data),
        .rd_b_idx  (snp_idx),
        .rd_b_state(b_state),
        .rd_b_tag  (b_tag),
        .rd_b_data (b_data)
    );

    // Snoop decode: writeback words on the bus are never acted upon.
    always_comb begin
        snp_upd = 1'b0;
        snp_wb  = 1'b0;
        snp_new = b_state;
        snp_hit = (b_state != LS_I) && (b_tag == snp_tag) && !bin_fl.wb;
        if (snp_hit) begin
            if (bin_fl.rd_miss) begin
                if (b_state == LS_M) begin
                    snp_wb  = 1'b1;
                    snp_new = LS_S;
                    snp_upd = 1'b1;
                end
            end else if (bin_fl.wr_miss) begin
                snp_wb  = (b_state == LS_M);
                snp_new = LS_I;
                snp_upd = 1'b1;
            end else if (bin_fl.inval) begin
                snp_new = LS_I;
                snp_upd = 1'b1;
            end
        end
    end

    assign snp_on_req   = snp_upd && (snp_idx == req_idx);
    assign fill_install = (state_q == ST_FILL_WAIT) && fill_valid;
    // The line being replaced by a fill is never M, so dropping its snoop update loses nothing.
    assign snp_we       = snp_upd && !(fill_install && snp_on_req);
    assign snp_wb_vld_d = snp_wb;
    assign hit          = (a_state != LS_I) && (a_tag == req_tag);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        cpu_we     = 1'b0;
        cpu_state  = LS_I;
        cpu_tag    = req_tag;
        cpu_data   = a_data;
        cnt_hit    = 1'b0;
        cnt_miss   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (execute_instruction) begin
                    req_wr_d   = instruction;
                    req_addr_d = address;
                    req_data_d = data_in;
                    busy_d     = 1'b1;
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!snp_upd) begin
                    if (hit && !req_wr_q) begin
                        data_out_d = a_data;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        cnt_hit    = 1'b1;
                    end else if (hit && a_state == LS_M) begin
                        cpu_we     = 1'b1;
                        cpu_state  = LS_M;
                        cpu_data   = req_data_q;
                        data_out_d = req_data_q;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        cnt_hit    = 1'b1;
                    end else if (hit) begin
                        state_d = ST_INV;
                        cnt_hit = 1'b1;
                    end else begin
                        state_d  = (a_state == LS_M) ? ST_WB : ST_MISS_REQ;
                        cnt_miss = 1'b1;
                    end
                end
            end
            ST_INV: begin
                if (snp_on_req) begin
                    state_d = ST_MISS_REQ;
                end else if (!snp_wb_vld_q) begin
                    cpu_we     = 1'b1;
                    cpu_state  = LS_M;
                    cpu_data   = req_data_q;
                    data_out_d = req_data_q;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WB: begin
                if (snp_on_req) begin
                    state_d = ST_MISS_REQ;
                end else if (!snp_wb_vld_q) begin
                    cpu_we    = 1'b1;
                    cpu_state = LS_I;
                    cpu_tag   = a_tag;
                    state_d   = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                if (!snp_wb_vld_q) begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (fill_valid) begin
                    cpu_we     = 1'b1;
                    cpu_state  = req_wr_q ? LS_M : LS_S;
                    cpu_data   = req_wr_q ? req_data_q : fill_data;
                    data_out_d = cpu_data;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            snp_wb_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            snp_wb_vld_q <= snp_wb_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        req_wr_q      <= req_wr_d;
        req_addr_q    <= req_addr_d;
        req_data_q    <= req_data_d;
        snp_wb_addr_q <= bin_addr;
        snp_wb_data_q <= b_data;
    end

    // A pending snoop writeback owns the bus; FSM messages hold their state meanwhile.
    always_comb begin
        bus_out = '0;
        if (snp_wb_vld_q) begin
            bus_out = {pack_flags(1'b0, 1'b0, 1'b0, 1'b1), snp_wb_addr_q, snp_wb_data_q};
        end else begin
            case (state_q)
                ST_INV:      bus_out = {pack_flags(1'b0, 1'b0, 1'b1, 1'b0), req_addr_q, {DATA_W{1'b0}}};
                ST_WB:       bus_out = {pack_flags(1'b0, 1'b0, 1'b0, 1'b1), a_tag, req_idx, a_data};
                ST_MISS_REQ: bus_out = {pack_flags(!req_wr_q, req_wr_q, 1'b0, 1'b0), req_addr_q, {DATA_W{1'b0}}};
                default:     bus_out = '0;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = busy_q;

`ifdef CACHE_NODE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (cnt_miss && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = cnt_hit ^ cnt_miss;
`endif

endmodule
